// File: rtl/round_key_scheduler.sv
// AES-256 key expansion: one schedule word per cycle into a 60-word store, served by round count.
// Optional KEY_ZEROIZE_EN adds a zeroize input that wipes the store and returns to idle.
module round_key_scheduler #(
  parameter int unsigned KEY_WORDS  = 8,
  parameter int unsigned NUM_ROUNDS = 14
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [255:0] key_in,
  input  logic         key_load,
  input  logic         encryption_flag,
  input  logic [3:0]   count,
`ifdef KEY_ZEROIZE_EN
  input  logic         zeroize,
`endif
  output logic [127:0] round_key,
  output logic         key_ready,
  output logic         key_busy
);

  localparam int unsigned TotalWords = 4 * (NUM_ROUNDS + 1);
  localparam int unsigned LastIdx    = TotalWords - 1;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StExpand = 2'd1;
  localparam logic [1:0] StReady  = 2'd2;

  // Forward S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] Sbox = {
    128'h637c777b_f26b6fc5_3001672b_fed7ab76, 128'hca82c97d_fa5947f0_add4a2af_9ca472c0,
    128'hb7fd9326_363ff7cc_34a5e5f1_71d83115, 128'h04c723c3_1896059a_071280e2_eb27b275,
    128'h09832c1a_1b6e5aa0_523bd6b3_29e32f84, 128'h53d100ed_20fcb15b_6acbbe39_4a4c58cf,
    128'hd0efaafb_434d3385_45f9027f_503c9fa8, 128'h51a3408f_929d38f5_bcb6da21_10fff3d2,
    128'hcd0c13ec_5f974417_c4a77e3d_645d1973, 128'h60814fdc_222a9088_46eeb814_de5e0bdb,
    128'he0323a0a_4906245c_c2d3ac62_9195e479, 128'he7c8376d_8dd54ea9_6c56f4ea_657aae08,
    128'hba78252e_1ca6b4c6_e8dd741f_4bbd8b8a, 128'h703eb566_4803f60e_613557b9_86c11d9e,
    128'he1f89811_69d98e94_9b1e87e9_ce5528df, 128'h8ca1890d_bfe64268_41992d0f_b054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return Sbox[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  logic [1:0]  state_q, state_d;
  logic [5:0]  idx_q, idx_d;
  logic [7:0]  rcon_q, rcon_d;
  logic [31:0] w_q [TotalWords];
  logic [31:0] w_d [TotalWords];

  logic [31:0] prev_word, sub_in, sub_out, f_out, new_word;
  logic        rot_step;

  // Single S-box path shared by the RotWord and plain SubWord steps.
  always_comb begin
    prev_word = w_q[idx_q - 6'd1];
    rot_step  = (idx_q[2:0] == 3'd0);
    sub_in    = rot_step ? {prev_word[23:0], prev_word[31:24]} : prev_word;
    sub_out   = sub_word(sub_in);
    if (rot_step) begin
      f_out = sub_out ^ {rcon_q, 24'h0};
    end else if (idx_q[2:0] == 3'd4) begin
      f_out = sub_out;
    end else begin
      f_out = prev_word;
    end
    new_word = w_q[idx_q - 6'd8] ^ f_out;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rcon_d  = rcon_q;
    w_d     = w_q;
    if (key_load) begin
      // A load restarts from any state; stale words are never served before READY.
      for (int i = 0; i < 8; i++) begin
        w_d[i] = key_in[255 - 32 * i -: 32];
      end
      idx_d   = KEY_WORDS[5:0];
      rcon_d  = 8'h01;
      state_d = StExpand;
    end else begin
      unique case (state_q)
        StIdle, StReady: ;
        StExpand: begin
          w_d[idx_q] = new_word;
          if (rot_step) begin
            rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
          end
          if (idx_q == LastIdx[5:0]) begin
            state_d = StReady;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
`ifdef KEY_ZEROIZE_EN
    if (zeroize) begin
      state_d = StIdle;
      idx_d   = 6'd0;
      rcon_d  = 8'h01;
      w_d     = '{default: '0};
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= 6'd0;
      rcon_q  <= 8'h01;
      w_q     <= '{default: '0};
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rcon_q  <= rcon_d;
      w_q     <= w_d;
    end
  end

  logic [3:0] key_sel;
  logic [5:0] base;

  always_comb begin
    key_ready = (state_q == StReady);
    key_busy  = (state_q == StExpand);
    if (count == 4'd15) begin
      key_sel = 4'd0;
    end else begin
      key_sel = encryption_flag ? count : (4'd14 - count);
    end
    base = {key_sel, 2'b00};
    if (key_ready && (count != 4'd15)) begin
      round_key = {w_q[base], w_q[base + 6'd1], w_q[base + 6'd2], w_q[base + 6'd3]};
    end else begin
      round_key = '0;
    end
  end

endmodule

// File: tb/tb_round_key_scheduler.sv
// Directed bench for round_key_scheduler: known-answer schedules, latency, abort, reset, zeroize.
module tb_round_key_scheduler;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [255:0] key_in = '0;
  logic         key_load = 1'b0;
  logic         encryption_flag = 1'b1;
  logic [3:0]   count = 4'd0;
  logic         zeroize = 1'b0;
  logic [127:0] round_key;
  logic         key_ready;
  logic         key_busy;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [255:0] Key1 =
    256'h00010203_04050607_08090a0b_0c0d0e0f_10111213_14151617_18191a1b_1c1d1e1f;
  localparam logic [255:0] KeyA3 =
    256'h603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4;
  localparam logic [127:0] K1R0  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K1R1  = 128'h101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] K1R2  = 128'ha573c29fa176c498a97fce93a572c09c;
  localparam logic [127:0] K1R14 = 128'h24fc79ccbf0979e9371ac23c6d68de36;

  localparam logic [31:0] A3W [60] = '{
    32'h603deb10, 32'h15ca71be, 32'h2b73aef0, 32'h857d7781,
    32'h1f352c07, 32'h3b6108d7, 32'h2d9810a3, 32'h0914dff4,
    32'h9ba35411, 32'h8e6925af, 32'ha51a8b5f, 32'h2067fcde,
    32'ha8b09c1a, 32'h93d194cd, 32'hbe49846e, 32'hb75d5b9a,
    32'hd59aecb8, 32'h5bf3c917, 32'hfee94248, 32'hde8ebe96,
    32'hb5a9328a, 32'h2678a647, 32'h98312229, 32'h2f6c79b3,
    32'h812c81ad, 32'hdadf48ba, 32'h24360af2, 32'hfab8b464,
    32'h98c5bfc9, 32'hbebd198e, 32'h268c3ba7, 32'h09e04214,
    32'h68007bac, 32'hb2df3316, 32'h96e939e4, 32'h6c518d80,
    32'hc814e204, 32'h76a9fb8a, 32'h5025c02d, 32'h59c58239,
    32'hde136967, 32'h6ccc5a71, 32'hfa256395, 32'h9674ee15,
    32'h5886ca5d, 32'h2e2f31d7, 32'h7e0af1fa, 32'h27cf73c3,
    32'h749c47ab, 32'h18501dda, 32'he2757e4f, 32'h7401905a,
    32'hcafaaae3, 32'he4d59b34, 32'h9adf6ace, 32'hbd10190d,
    32'hfe4890d1, 32'he6188d0b, 32'h046df344, 32'h706c631e
  };

  round_key_scheduler dut (
    .clk             (clk),
    .rst             (rst),
    .key_in          (key_in),
    .key_load        (key_load),
    .encryption_flag (encryption_flag),
    .count           (count),
`ifdef KEY_ZEROIZE_EN
    .zeroize         (zeroize),
`endif
    .round_key       (round_key),
    .key_ready       (key_ready),
    .key_busy        (key_busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic serve(input string tag, input logic enc, input logic [3:0] c,
                       input logic [127:0] exp);
    encryption_flag = enc;
    count = c;
    #1;
    check_eq(tag, round_key, exp);
  endtask

  task automatic load_key(input logic [255:0] k);
    @(negedge clk);
    key_in = k;
    key_load = 1'b1;
    @(posedge clk);
    #1;
    key_load = 1'b0;
  endtask

  // Counts edges after the load edge until key_ready; must be exactly 52.
  task automatic wait_ready(input string tag);
    int cycles;
    cycles = 0;
    while (!key_ready && cycles < 200) begin
      @(posedge clk);
      #1;
      cycles++;
      if (cycles == 1) check_eq({tag, "_busy_early"}, 128'(key_busy), 128'd1);
    end
    check_eq({tag, "_latency"}, 128'(cycles), 128'd52);
    check_eq({tag, "_busy_done"}, 128'(key_busy), 128'd0);
  endtask

  function automatic logic [127:0] a3_key(input int k);
    return {A3W[4 * k], A3W[4 * k + 1], A3W[4 * k + 2], A3W[4 * k + 3]};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("rst_ready", 128'(key_ready), 128'd0);
    check_eq("rst_busy", 128'(key_busy), 128'd0);
    serve("rst_rk", 1'b1, 4'd0, '0);

    load_key(Key1);
    wait_ready("k1");
    serve("k1_enc0", 1'b1, 4'd0, K1R0);
    serve("k1_enc1", 1'b1, 4'd1, K1R1);
    serve("k1_enc2", 1'b1, 4'd2, K1R2);
    serve("k1_enc14", 1'b1, 4'd14, K1R14);
    serve("k1_enc15", 1'b1, 4'd15, '0);
    serve("k1_dec0", 1'b0, 4'd0, K1R14);
    serve("k1_dec12", 1'b0, 4'd12, K1R2);
    serve("k1_dec14", 1'b0, 4'd14, K1R0);
    serve("k1_dec15", 1'b0, 4'd15, '0);

    load_key(KeyA3);
    wait_ready("a3");
    for (int k = 0; k < 15; k++) begin
      serve($sformatf("a3_enc%0d", k), 1'b1, 4'(k), a3_key(k));
    end
    serve("a3_dec3", 1'b0, 4'd3, a3_key(11));
    serve("a3_dec14", 1'b0, 4'd14, a3_key(0));

    // Abort mid-expansion with a new key.
    load_key(KeyA3);
    repeat (19) @(posedge clk);
    #1;
    check_eq("abort_busy", 128'(key_busy), 128'd1);
    check_eq("abort_ready", 128'(key_ready), 128'd0);
    load_key(Key1);
    wait_ready("abort");
    serve("abort_enc2", 1'b1, 4'd2, K1R2);
    serve("abort_enc14", 1'b1, 4'd14, K1R14);
    serve("abort_dec14", 1'b0, 4'd14, K1R0);

    // Reset mid-expansion.
    load_key(KeyA3);
    repeat (29) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("midrst_busy", 128'(key_busy), 128'd0);
    check_eq("midrst_ready", 128'(key_ready), 128'd0);
    serve("midrst_rk", 1'b1, 4'd0, '0);

    // Reset and load together: reset wins.
    @(negedge clk);
    rst = 1'b1;
    key_in = Key1;
    key_load = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    key_load = 1'b0;
    @(posedge clk);
    #1;
    check_eq("rstload_busy", 128'(key_busy), 128'd0);
    check_eq("rstload_ready", 128'(key_ready), 128'd0);

    load_key(Key1);
    wait_ready("reload");
    serve("reload_enc2", 1'b1, 4'd2, K1R2);
    serve("reload_dec0", 1'b0, 4'd0, K1R14);

`ifdef KEY_ZEROIZE_EN
    @(negedge clk);
    zeroize = 1'b1;
    @(posedge clk);
    #1;
    zeroize = 1'b0;
    check_eq("zero_ready", 128'(key_ready), 128'd0);
    serve("zero_rk", 1'b1, 4'd0, '0);
    @(negedge clk);
    zeroize = 1'b1;
    key_in = Key1;
    key_load = 1'b1;
    @(posedge clk);
    #1;
    zeroize = 1'b0;
    key_load = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("zeroload_busy", 128'(key_busy), 128'd0);
    check_eq("zeroload_ready", 128'(key_ready), 128'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
